// File: rtl/deser_stream_pkg.sv
// ----------------------------------------------------------------------------
// deser_pkg : shared types and helpers for the serial-to-parallel converter
// Revision  : 1.0
// ----------------------------------------------------------------------------
`default_nettype none

package deser_pkg;

  typedef enum logic {
    ORDER_LSB_FIRST = 1'b0,
    ORDER_MSB_FIRST = 1'b1
  } bit_order_e;

  // Arrival counts and bit positions are carried as plain integers between helpers.
  typedef int bit_count_t;

  function automatic bit_count_t len_width(input bit_count_t data_w);
    return $clog2(data_w + 1);
  endfunction

  function automatic bit_count_t bit_index(input bit_count_t arrival,
                                           input bit_count_t data_w,
                                           input bit         msb_first);
    return msb_first ? (data_w - 1 - arrival) : arrival;
  endfunction

endpackage

`default_nettype wire

// File: rtl/deser_stream_if.sv
// ----------------------------------------------------------------------------
// deser_stream_if : serial input and parallel valid/ready output bundle
// Revision        : 1.0
// ----------------------------------------------------------------------------
`default_nettype none

interface deser_stream_if #(
  parameter int DATA_W = 16,
  parameter int LEN_W  = $clog2(DATA_W + 1)
);

  logic              data_i;
  logic              data_val_i;
  logic              data_ready_o;
  logic              flush_i;
  logic [DATA_W-1:0] deser_data_o;
  logic [LEN_W-1:0]  deser_len_o;
  logic              deser_data_val_o;
  logic              deser_data_ready_i;

  modport slave (
    input  data_i, data_val_i, flush_i, deser_data_ready_i,
    output data_ready_o, deser_data_o, deser_len_o, deser_data_val_o
  );

  modport master (
    output data_i, data_val_i, flush_i, deser_data_ready_i,
    input  data_ready_o, deser_data_o, deser_len_o, deser_data_val_o
  );

endinterface

`default_nettype wire

// File: rtl/deser_out_reg.sv
// ----------------------------------------------------------------------------
// deser_out_reg : one-entry valid/ready holding register for a word and length
// Revision      : 1.0
// ----------------------------------------------------------------------------
`default_nettype none

module deser_out_reg #(
  parameter int DATA_W = 16,
  parameter int LEN_W  = 5
) (
  input  logic              clk_i,
  input  logic              srst_i,
  input  logic              i_load,
  input  logic [DATA_W-1:0] i_data,
  input  logic [LEN_W-1:0]  i_len,
  input  logic              i_ready,
  output logic              o_valid,
  output logic [DATA_W-1:0] o_data,
  output logic [LEN_W-1:0]  o_len,
  output logic              o_free
);

  logic              r_valid;
  logic [DATA_W-1:0] r_data;
  logic [LEN_W-1:0]  r_len;

  // Free when empty or being drained this edge, so a new word can follow with no gap.
  assign o_free  = !r_valid || i_ready;
  assign o_valid = r_valid;
  assign o_data  = r_data;
  assign o_len   = r_len;

  always_ff @(posedge clk_i) begin
    if (srst_i) begin
      r_valid <= 1'b0;
      r_data  <= '0;
      r_len   <= '0;
    end else if (i_load) begin
      r_valid <= 1'b1;
      r_data  <= i_data;
      r_len   <= i_len;
    end else if (r_valid && i_ready) begin
      r_valid <= 1'b0;
    end
  end

endmodule

`default_nettype wire

// File: rtl/deser_stream.sv
// ----------------------------------------------------------------------------
// deser_stream : parametrised serial-to-parallel converter with flush/backpressure
// Revision     : 1.0
// ----------------------------------------------------------------------------
`default_nettype none

module deser_stream
  import deser_pkg::*;
#(
  parameter int DATA_W    = 16,
  parameter bit MSB_FIRST = 1'b1
) (
  input  logic          clk_i,
  input  logic          srst_i,
  deser_stream_if.slave bus
);

  localparam int               LEN_W      = len_width(DATA_W);
  localparam logic [LEN_W-1:0] c_full_cnt = LEN_W'(DATA_W);

  logic [DATA_W-1:0] r_coll;
  logic [LEN_W-1:0]  r_cnt;
  logic              r_pend;

  logic [DATA_W-1:0] w_base_coll, w_coll_ins, w_coll_nxt, w_load_data, w_out_data;
  logic [LEN_W-1:0]  w_base_cnt, w_cnt_ins, w_cnt_nxt, w_load_len, w_out_len;
  logic              w_bit_acc, w_close, w_load, w_pend_nxt, w_out_free, w_out_valid;

  // A pending word always leaves on an edge where the output is free, so ready can track that.
  assign bus.data_ready_o = !r_pend || w_out_free;

  always_comb begin
    w_bit_acc   = bus.data_val_i && bus.data_ready_o;
    w_base_coll = r_pend ? '0 : r_coll;
    w_base_cnt  = r_pend ? '0 : r_cnt;

    w_coll_ins = w_base_coll;
    for (int i = 0; i < DATA_W; i++) begin
      if (w_bit_acc && (bit_index(int'(w_base_cnt), DATA_W, MSB_FIRST) == i)) begin
        w_coll_ins[i] = bus.data_i;
      end
    end
    w_cnt_ins = w_base_cnt + LEN_W'(w_bit_acc);

    w_close = (w_cnt_ins == c_full_cnt) ||
              (bus.flush_i && !r_pend && (w_cnt_ins != '0));

    w_load      = 1'b0;
    w_load_data = w_coll_ins;
    w_load_len  = w_cnt_ins;
    w_coll_nxt  = w_coll_ins;
    w_cnt_nxt   = w_cnt_ins;
    w_pend_nxt  = 1'b0;

    if (r_pend) begin
      if (w_out_free) begin
        // Held word moves out; the collector restarts with any bit taken this edge.
        w_load      = 1'b1;
        w_load_data = r_coll;
        w_load_len  = r_cnt;
      end else begin
        w_coll_nxt = r_coll;
        w_cnt_nxt  = r_cnt;
        w_pend_nxt = 1'b1;
      end
    end else if (w_close) begin
      if (w_out_free) begin
        w_load     = 1'b1;
        w_coll_nxt = '0;
        w_cnt_nxt  = '0;
      end else begin
        w_pend_nxt = 1'b1;
      end
    end
  end

  always_ff @(posedge clk_i) begin
    if (srst_i) begin
      r_coll <= '0;
      r_cnt  <= '0;
      r_pend <= 1'b0;
    end else begin
      r_coll <= w_coll_nxt;
      r_cnt  <= w_cnt_nxt;
      r_pend <= w_pend_nxt;
    end
  end

  deser_out_reg #(
    .DATA_W (DATA_W),
    .LEN_W  (LEN_W)
  ) u_out_reg (
    .clk_i   (clk_i),
    .srst_i  (srst_i),
    .i_load  (w_load),
    .i_data  (w_load_data),
    .i_len   (w_load_len),
    .i_ready (bus.deser_data_ready_i),
    .o_valid (w_out_valid),
    .o_data  (w_out_data),
    .o_len   (w_out_len),
    .o_free  (w_out_free)
  );

  assign bus.deser_data_val_o = w_out_valid;
  assign bus.deser_data_o     = w_out_data;
  assign bus.deser_len_o      = w_out_len;

endmodule

`default_nettype wire
